instr_queue: RTL and testbench

- Decoded instruction FIFO between fetch and the Tomasulo issue stage.
- Accepts fetched instructions with a valid/ready handshake and decodes register indices, opcode, funct fields and immediates at enqueue.
- Stores decoded entries in a circular buffer and presents the head entry to issue via iq_assert/iq_read.
- Clears all entries on a branch-mispredict flush.

---
 rtl/instr_queue.sv | 194 +++++++++++++++++++
 tb/tb_instr_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - decoded instruction FIFO between fetch and issue
// Decodes RV32I fields at enqueue and presents the head entry to issue.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  input  logic [2:0]       fetch_pc_tag,
  input  logic [31:0]      fetch_target_predict,
  input  logic             flush,
  output logic             iq_assert,
  input  logic             iq_read,
  output logic [4:0]       rd,
  output logic [4:0]       r1_i,
  output logic [4:0]       r2_i,
  output logic [31:0]      src2_i,
  output logic [6:0]       opcode_i,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [2:0]       pc_save,
  output logic [31:0]      target_predict_i,
  output logic [31:0]      inst_pc,
  output logic [31:0]      instruction_i,
  output logic [31:0]      b_imm,
  output logic [31:0]      j_imm,
  output logic [PTR_W:0]   count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_ACCEL = 7'b0001011;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [2:0]  tag;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic [DEPTH-1:0]   r_valid;

  logic [31:0] w_i;
  logic [6:0]  w_op;
  logic        w_known;
  logic        w_rd_zero;
  logic        w_r1_zero;
  logic        w_r2_keep;
  logic [31:0] w_imm;
  logic [31:0] w_i_imm;
  logic [31:0] w_s_imm;
  logic [31:0] w_u_imm;
  logic [31:0] w_b_imm;
  logic [31:0] w_j_imm;
  entry_t      w_entry;
  entry_t      w_head;
  logic        w_push;
  logic        w_store;
  logic        w_pop;
  logic        w_out_en;

  assign w_i     = fetch_instr;
  assign w_op    = w_i[6:0];
  assign w_i_imm = {{20{w_i[31]}}, w_i[31:20]};
  assign w_s_imm = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
  assign w_u_imm = {w_i[31:12], 12'b0};
  assign w_b_imm = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
  assign w_j_imm = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};

  always_comb begin
    w_known   = 1'b1;
    w_imm     = '0;
    w_rd_zero = 1'b0;
    w_r1_zero = 1'b0;
    w_r2_keep = 1'b0;
    case (w_op)
      OP_IMM, OP_LOAD, OP_JALR: w_imm = w_i_imm;
      OP_STORE: begin
        w_imm     = w_s_imm;
        w_rd_zero = 1'b1;
        w_r2_keep = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm     = w_u_imm;
        w_r1_zero = 1'b1;
      end
      OP_JAL: begin
        w_imm     = w_j_imm;
        w_r1_zero = 1'b1;
      end
      OP_BR: begin
        w_rd_zero = 1'b1;
        w_r2_keep = 1'b1;
      end
      OP_REG, OP_ACCEL: w_r2_keep = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  always_comb begin
    w_entry.rd     = w_rd_zero ? 5'd0 : w_i[11:7];
    w_entry.rs1    = w_r1_zero ? 5'd0 : w_i[19:15];
    w_entry.rs2    = w_r2_keep ? w_i[24:20] : 5'd0;
    w_entry.imm    = w_imm;
    w_entry.opcode = w_op;
    w_entry.funct3 = w_i[14:12];
    w_entry.funct7 = w_i[31:25];
    w_entry.tag    = fetch_pc_tag;
    w_entry.target = fetch_target_predict;
    w_entry.pc     = fetch_pc;
    w_entry.instr  = w_i;
    w_entry.b_imm  = w_b_imm;
    w_entry.j_imm  = w_j_imm;
  end

  assign fetch_ready = (r_count != FULL) && !flush && reset;
  assign iq_assert   = (r_count != '0);
  assign count       = r_count;
  assign w_push      = fetch_valid && fetch_ready;
  // Unknown opcodes complete the handshake but are discarded
  assign w_store     = w_push && w_known;
  assign w_pop       = iq_read && iq_assert && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_head          <= r_head + PTR_W'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (w_store) begin
        r_tail          <= r_tail + PTR_W'(1);
        r_valid[r_tail] <= 1'b1;
      end
      r_count <= r_count + (PTR_W+1)'(w_store) - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_tail] <= w_entry;
  end

  assign w_head   = r_mem[r_head];
  assign w_out_en = iq_assert && r_valid[r_head];

  assign rd               = w_out_en ? w_head.rd     : '0;
  assign r1_i             = w_out_en ? w_head.rs1    : '0;
  assign r2_i             = w_out_en ? w_head.rs2    : '0;
  assign src2_i           = w_out_en ? w_head.imm    : '0;
  assign opcode_i         = w_out_en ? w_head.opcode : '0;
  assign funct3           = w_out_en ? w_head.funct3 : '0;
  assign funct7           = w_out_en ? w_head.funct7 : '0;
  assign pc_save          = w_out_en ? w_head.tag    : '0;
  assign target_predict_i = w_out_en ? w_head.target : '0;
  assign inst_pc          = w_out_en ? w_head.pc     : '0;
  assign instruction_i    = w_out_en ? w_head.instr  : '0;
  assign b_imm            = w_out_en ? w_head.b_imm  : '0;
  assign j_imm            = w_out_en ? w_head.j_imm  : '0;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed self-checking bench for instr_queue
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [2:0]  fetch_pc_tag;
  logic [31:0] fetch_target_predict;
  logic        flush;
  logic        iq_assert;
  logic        iq_read;
  logic [4:0]  rd;
  logic [4:0]  r1_i;
  logic [4:0]  r2_i;
  logic [31:0] src2_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [2:0]  pc_save;
  logic [31:0] target_predict_i;
  logic [31:0] inst_pc;
  logic [31:0] instruction_i;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [3:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  instr_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_pc_tag(fetch_pc_tag), .fetch_target_predict(fetch_target_predict),
    .flush(flush), .iq_assert(iq_assert), .iq_read(iq_read),
    .rd(rd), .r1_i(r1_i), .r2_i(r2_i), .src2_i(src2_i),
    .opcode_i(opcode_i), .funct3(funct3), .funct7(funct7),
    .pc_save(pc_save), .target_predict_i(target_predict_i),
    .inst_pc(inst_pc), .instruction_i(instruction_i),
    .b_imm(b_imm), .j_imm(j_imm), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = '0;
    fetch_pc = '0;
    fetch_pc_tag = '0;
    fetch_target_predict = '0;
    flush = 1'b0;
    iq_read = 1'b0;

    #1;
    check("rst_iq_assert", 32'(iq_assert), 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_src2", src2_i, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_ready", 32'(fetch_ready), 32'd1);

    // addi x5,x1,-3
    fetch_valid = 1'b1;
    fetch_instr = 32'hFFD08293;
    fetch_pc = 32'h100;
    fetch_pc_tag = 3'd5;
    fetch_target_predict = 32'h200;
    check("addi_same_cycle_empty", 32'(iq_assert), 32'd0);
    tick();
    fetch_valid = 1'b0;
    check("addi_assert", 32'(iq_assert), 32'd1);
    check("addi_opcode", 32'(opcode_i), 32'h13);
    check("addi_rd", 32'(rd), 32'd5);
    check("addi_r1", 32'(r1_i), 32'd1);
    check("addi_r2", 32'(r2_i), 32'd0);
    check("addi_src2", src2_i, 32'hFFFFFFFD);
    check("addi_funct3", 32'(funct3), 32'd0);
    check("addi_count", 32'(count), 32'd1);
    check("addi_pc", inst_pc, 32'h100);
    check("addi_tag", 32'(pc_save), 32'd5);
    check("addi_target", target_predict_i, 32'h200);
    check("addi_instr", instruction_i, 32'hFFD08293);
    iq_read = 1'b1;
    tick();
    iq_read = 1'b0;
    check("addi_pop_count", 32'(count), 32'd0);
    check("addi_pop_assert", 32'(iq_assert), 32'd0);
    check("empty_rd_zero", 32'(rd), 32'd0);

    // sw x2,8(x3)
    fetch_valid = 1'b1;
    fetch_instr = 32'h0021A423;
    tick();
    fetch_valid = 1'b0;
    check("sw_opcode", 32'(opcode_i), 32'h23);
    check("sw_rd", 32'(rd), 32'd0);
    check("sw_r1", 32'(r1_i), 32'd3);
    check("sw_r2", 32'(r2_i), 32'd2);
    check("sw_src2", src2_i, 32'h8);
    check("sw_funct3", 32'(funct3), 32'd2);
    iq_read = 1'b1;
    tick();
    iq_read = 1'b0;

    // lui x7,0x12345
    fetch_valid = 1'b1;
    fetch_instr = 32'h123453B7;
    tick();
    fetch_valid = 1'b0;
    check("lui_rd", 32'(rd), 32'd7);
    check("lui_r1", 32'(r1_i), 32'd0);
    check("lui_r2", 32'(r2_i), 32'd0);
    check("lui_src2", src2_i, 32'h12345000);
    iq_read = 1'b1;
    tick();
    iq_read = 1'b0;

    // beq x1,x2,+16
    fetch_valid = 1'b1;
    fetch_instr = 32'h00208863;
    tick();
    fetch_valid = 1'b0;
    check("br_rd", 32'(rd), 32'd0);
    check("br_r1", 32'(r1_i), 32'd1);
    check("br_r2", 32'(r2_i), 32'd2);
    check("br_src2", src2_i, 32'd0);
    check("br_bimm", b_imm, 32'd16);
    check("br_jimm", j_imm, 32'h00008002);
    iq_read = 1'b1;
    tick();
    iq_read = 1'b0;

    // Fill to full; pointers start mid-buffer so the pushes wrap
    fetch_instr = 32'h00000013;
    fetch_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fetch_pc = 32'h1000 + 32'(4 * k);
      tick();
    end
    fetch_pc = 32'h1020;
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(fetch_ready), 32'd0);
    check("full_head_pc", inst_pc, 32'h1000);
    iq_read = 1'b1;
    tick();
    check("full_pop_only", 32'(count), 32'd7);
    check("after_pop_ready", 32'(fetch_ready), 32'd1);
    tick();
    check("push_pop_count", 32'(count), 32'd7);
    fetch_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("drain_pc_%0d", k), inst_pc, 32'h1008 + 32'(4 * k));
      tick();
    end
    iq_read = 1'b0;
    check("drain_count", 32'(count), 32'd0);

    // Flush beats a simultaneous push and pop
    fetch_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      fetch_pc = 32'h2000 + 32'(4 * k);
      tick();
    end
    check("pre_flush_count", 32'(count), 32'd5);
    fetch_pc = 32'h3000;
    iq_read = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0;
    iq_read = 1'b0;
    fetch_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_assert", 32'(iq_assert), 32'd0);
    fetch_valid = 1'b1;
    fetch_pc = 32'h4000;
    tick();
    fetch_valid = 1'b0;
    check("post_flush_pc", inst_pc, 32'h4000);
    check("post_flush_count", 32'(count), 32'd1);

    // Asynchronous reset between edges
    fetch_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fetch_pc = 32'h5000 + 32'(4 * k);
      tick();
    end
    fetch_valid = 1'b0;
    check("pre_areset_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("areset_assert", 32'(iq_assert), 32'd0);
    check("areset_count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("areset_ready", 32'(fetch_ready), 32'd1);
    check("areset_count_hold", 32'(count), 32'd0);

    // Undefined opcode is accepted and discarded
    fetch_valid = 1'b1;
    fetch_instr = 32'h0000007F;
    #1;
    check("undef_ready", 32'(fetch_ready), 32'd1);
    tick();
    fetch_valid = 1'b0;
    check("undef_count", 32'(count), 32'd0);
    check("undef_assert", 32'(iq_assert), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
